// File: rtl/seq_scan_pkg.sv
// Shared definitions for the "1100" detector scan controller.
package seq_scan_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    function automatic logic state_is_active(input scan_state_e s);
        return (s == ST_SHIFT) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/seq_scan_ctrl.sv
// Feeds a captured word MSB-first into an external "1100" Moore detector and
// tallies its hit pulses, recording the first and last completing bit index.
//
// state | meaning
// IDLE  | detector held clear, waiting for start
// SHIFT | presenting bit k of the captured word
// DRAIN | one extra cycle to catch a hit caused by the final bit
// DONE  | one-cycle done pulse, results valid
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW   = $clog2(WIDTH + 1),
    localparam int unsigned PW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] word_in,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [CW-1:0]    hit_count,
    output logic [PW-1:0]    first_pos,
    output logic [PW-1:0]    last_pos,
    output logic             det_bit,
    output logic             det_clr,
    input  logic             det_hit
);

    localparam logic [PW-1:0] LAST_IDX = PW'(WIDTH - 1);

    scan_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [PW-1:0]    k_q, k_d;
    logic             found_q, found_d;
    logic [CW-1:0]    hit_count_q, hit_count_d;
    logic [PW-1:0]    first_pos_q, first_pos_d;
    logic [PW-1:0]    last_pos_q, last_pos_d;

    logic             hit_ok;
    logic [PW-1:0]    hit_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            k_q         <= '0;
            found_q     <= 1'b0;
            hit_count_q <= '0;
            first_pos_q <= '0;
            last_pos_q  <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            k_q         <= k_d;
            found_q     <= found_d;
            hit_count_q <= hit_count_d;
            first_pos_q <= first_pos_d;
            last_pos_q  <= last_pos_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        k_d         = k_q;
        found_d     = found_q;
        hit_count_d = hit_count_q;
        first_pos_d = first_pos_q;
        last_pos_d  = last_pos_q;
        hit_ok      = 1'b0;
        hit_idx     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SHIFT;
                    sr_d        = word_in;
                    k_d         = '0;
                    found_d     = 1'b0;
                    hit_count_d = '0;
                    first_pos_d = '0;
                    last_pos_d  = '0;
                end
            end
            ST_SHIFT: begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
                // The detector lags one cycle, so a hit now belongs to bit k-1.
                if (det_hit && (k_q != '0)) begin
                    hit_ok  = 1'b1;
                    hit_idx = k_q - PW'(1);
                end
                if (k_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + PW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                if (det_hit) begin
                    hit_ok  = 1'b1;
                    hit_idx = LAST_IDX;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hit_ok) begin
            hit_count_d = hit_count_q + CW'(1);
            last_pos_d  = hit_idx;
            if (!found_q) begin
                first_pos_d = hit_idx;
                found_d     = 1'b1;
            end
        end
    end

    assign busy      = state_is_active(state_q);
    assign done      = (state_q == ST_DONE);
    assign det_clr   = !state_is_active(state_q);
    assign det_bit   = (state_q == ST_SHIFT) ? sr_q[WIDTH-1] : 1'b0;
    assign found     = found_q;
    assign hit_count = hit_count_q;
    assign first_pos = first_pos_q;
    assign last_pos  = last_pos_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench: behavioural "1100" detector beside the controller,
// results compared against a word-level pattern-search reference.
module tb_seq_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] word_in;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  hit_count;
    logic [3:0]  first_pos;
    logic [3:0]  last_pos;
    logic        det_bit;
    logic        det_clr;
    logic        det_hit;

    int errors = 0;
    int checks = 0;

    seq_scan_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word_in   (word_in),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .hit_count (hit_count),
        .first_pos (first_pos),
        .last_pos  (last_pos),
        .det_bit   (det_bit),
        .det_clr   (det_clr),
        .det_hit   (det_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moore "1100" detector: output high in its hit state, which always
    // returns to the start state and ignores the bit presented meanwhile.
    logic [3:0] d_hist;
    always @(posedge clk) begin
        if (det_clr || det_hit) begin
            d_hist  <= 4'b0000;
            det_hit <= 1'b0;
        end else begin
            d_hist  <= {d_hist[2:0], det_bit};
            det_hit <= ({d_hist[2:0], det_bit} == 4'b1100);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hits are the non-overlapping occurrences of 1100 scanning MSB first,
    // where the bit right after each hit cannot start a new occurrence.
    function automatic void ref_scan(input logic [15:0] w, output int cnt,
                                     output int first, output int last);
        int prev;
        prev  = -2;
        cnt   = 0;
        first = 0;
        last  = 0;
        for (int i = 3; i < 16; i++) begin
            if ((i - 3 >= prev + 2) && w[15-(i-3)] && w[15-(i-2)] &&
                !w[15-(i-1)] && !w[15-i]) begin
                if (cnt == 0) first = i;
                last = i;
                cnt++;
                prev = i;
            end
        end
    endfunction

    // mode 0: plain scan; mode 1: extra start pulse during SHIFT cycle 5
    task automatic scan(input logic [15:0] w, input int mode, input string nm);
        int ecnt, efirst, elast;
        int c, done_at;
        logic [15:0] bits;
        bit busy_ok, clr_ok;
        ref_scan(w, ecnt, efirst, elast);
        @(negedge clk);
        word_in = w;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        word_in = 16'($urandom);
        c       = 1;
        done_at = -1;
        bits    = '0;
        busy_ok = 1'b1;
        clr_ok  = 1'b1;
        while (done_at < 0 && c <= 40) begin
            if (c <= 16) bits[16-c] = det_bit;
            if (c <= 17 && busy !== 1'b1) busy_ok = 1'b0;
            if (c <= 17 && det_clr !== 1'b0) clr_ok = 1'b0;
            if (done === 1'b1) done_at = c;
            if (done_at < 0) begin
                if (mode == 1 && c == 6) begin
                    start   = 1'b1;
                    word_in = ~w;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        chk({nm, " latency"}, done_at, 18);
        chk({nm, " det_bits"}, bits, w);
        chk({nm, " busy"}, busy_ok, 1);
        chk({nm, " det_clr_low"}, clr_ok, 1);
        chk({nm, " det_clr_done"}, det_clr, 1);
        chk({nm, " hit_count"}, hit_count, ecnt);
        chk({nm, " found"}, found, (ecnt > 0));
        chk({nm, " first_pos"}, first_pos, efirst);
        chk({nm, " last_pos"}, last_pos, elast);
        @(negedge clk);
        chk({nm, " done_width"}, done, 0);
        chk({nm, " hold_count"}, hit_count, ecnt);
        chk({nm, " hold_last"}, last_pos, elast);
    endtask

    task automatic scan_with_reset();
        int seen;
        @(negedge clk);
        word_in = 16'hC000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst pre_count", hit_count, 1);
        chk("rst pre_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst det_clr", det_clr, 1);
        chk("rst hit_count", hit_count, 0);
        chk("rst found", found, 0);
        chk("rst done", done, 0);
        chk("rst det_bit", det_bit, 0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("rst no_done", seen, 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        word_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset det_clr", det_clr, 1);
        chk("reset hit_count", hit_count, 0);
        chk("reset found", found, 0);
        chk("reset first_pos", first_pos, 0);
        chk("reset last_pos", last_pos, 0);

        scan(16'hC000, 0, "w_C000");
        chk("w_C000 abs_first", first_pos, 3);
        scan(16'h000C, 0, "w_000C");
        chk("w_000C abs_last", last_pos, 15);
        scan(16'hCCCC, 0, "w_CCCC");
        chk("w_CCCC abs_count", hit_count, 2);
        chk("w_CCCC abs_last", last_pos, 11);
        scan(16'hFFFF, 0, "w_FFFF");
        chk("w_FFFF abs_found", found, 0);
        scan(16'hC000, 1, "start_ignored");
        chk("start_ignored abs_count", hit_count, 1);

        scan_with_reset();
        scan(16'h3C3C, 0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            logic [15:0] rw;
            rw = 16'($urandom);
            if (i % 3 == 0) rw[(i % 12) +: 4] = 4'b1100;
            scan(rw, (i % 5 == 0) ? 1 : 0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Scheduler that sequences the serial "1100" Moore sequence detector over a parallel word.
- On start it captures WIDTH bits and shifts them MSB-first, one per clock, into the detector.
- It counts the detector's hit pulses and records the first and last bit index that completed a match.
- Sits between a register or host interface and the external detector instance; the detector is wired to it at the next level up.

Parameters:
- WIDTH, 16, bits per scanned word; must be >= 4.
- CW, $clog2(WIDTH+1), width of the hit counter (derived localparam).
- PW, $clog2(WIDTH), width of the position fields (derived localparam).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to scan word_in; accepted only in IDLE.
- word_in  in  WIDTH  word to scan; sampled on the accepting edge.
- busy  out  1  high in SHIFT and DRAIN.
- done  out  1  one-cycle pulse in DONE.
- found  out  1  at least one hit seen in the last scan.
- hit_count  out  CW  number of hits in the last scan.
- first_pos  out  PW  bit index (0 = MSB) that completed the first hit.
- last_pos  out  PW  bit index that completed the most recent hit.
- det_bit  out  1  serial bit driven to the detector's seqIn.
- det_clr  out  1  drives the detector's rst; holds it in its idle state.
- det_hit  in  1  the detector's detected output.

Behaviour:
- States: IDLE, SHIFT, DRAIN, DONE; the encoding lives in the package.
- Reset: state = IDLE, busy = 0, done = 0, found = 0, hit_count = 0, first_pos = 0, last_pos = 0, det_bit = 0, det_clr = 1, bit index k = 0.
- det_clr = 1 in IDLE and DONE, 0 in SHIFT and DRAIN; it is decoded from the registered state (Moore).
- IDLE -> SHIFT on start:
  - capture word_in into the shift register;
  - set k = 0;
  - clear found, hit_count, first_pos and last_pos.
- SHIFT cycle k (k = 0..WIDTH-1):
  - det_bit = word[WIDTH-1-k], driven from the shift register's MSB;
  - the register shifts left at the end of the cycle and k increments;
  - after k = WIDTH-1, go to DRAIN.
- Hit attribution: the detector registers bit k at the end of cycle k, so a hit caused by bit k appears in cycle k+1.
  - det_hit is sampled in SHIFT cycles with k >= 1 and in the single DRAIN cycle.
  - A hit sampled in SHIFT cycle k is attributed to index k-1; a hit in DRAIN is attributed to index WIDTH-1.
  - det_hit in SHIFT cycle k = 0, IDLE or DONE is ignored.
- On each accepted hit:
  - hit_count increments (it cannot overflow, since the maximum is WIDTH/4);
  - last_pos is set to the attributed index;
  - if found = 0, first_pos is set to the same index and found is set to 1.
- DRAIN: det_bit = 0; one cycle; then DONE.
- DONE: done = 1 for one cycle; then IDLE.
- Results hold from DONE until the next accepted start.
- Latency: start edge to done pulse is WIDTH + 2 cycles.
- start is ignored while busy and in DONE. A start asserted on the same edge the FSM enters IDLE is accepted on that next IDLE cycle only if it is still high.
- Detector behaviour that is not compensated for: the bit presented while the detector is in its hit state is consumed with no effect. The controller does not re-present it.
- rst mid-scan returns every output to its reset value on the next edge. det_clr = 1 from that edge onward, so no partial result survives.
- No combinational path from det_hit or start to any output.

Decomposition:
- Shared package seq_scan_pkg holds:
  - the state typedef or localparams for IDLE, SHIFT, DRAIN, DONE;
  - the default WIDTH.
- No sub-module: the shift register, bit counter and hit logic are small enough to stay inline.
- The detector is not instantiated inside this block; the bench and the next-level top instantiate moore next to it.

Test Plan:
- rst held 3 cycles, then released -> busy = 0, done = 0, det_clr = 1, hit_count = 0 and found = 0 on the first post-reset cycle.
- WIDTH = 16, word_in = 0xC000, start -> det_bit sequence 1,1,0,0,0…; done on cycle 18 after start; hit_count = 1, first_pos = 3, last_pos = 3, found = 1.
- word_in = 0x000C -> the only hit arrives in DRAIN; hit_count = 1, first_pos = last_pos = 15.
- word_in = 0xCCCC -> hit_count = 2, first_pos = 3, last_pos = 11 (the bits at indices 4 and 12 are swallowed by the detector); word_in = 0xFFFF -> hit_count = 0, found = 0.
- start pulsed again at SHIFT cycle 5 with a different word_in -> ignored; results match the first word; busy stays high throughout.
- rst asserted at SHIFT cycle 8 of 0xC000 -> next cycle state IDLE, det_clr = 1, hit_count = 0, found = 0, no done pulse; a fresh start then completes normally.
